uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx8 transmitter between NUM_REQ byte-stream requesters, for example controller event reports and board dump.
- Arbitration is round-robin at frame granularity: once a requester starts a frame, it owns the UART until its byte marked last is sent.
- Sequences the uart_tx8 start/busy handshake, including a watchdog on a missing busy response.
- Sits in top between the requesting blocks and uart_tx8; drives uart_tx8 data/start and observes its busy.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, byte width; must match uart_tx8 data.
- BUSY_TIMEOUT, 16, max cycles after the start pulse to wait for busy to rise.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  NUM_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  byte closes requester i's frame.
- req_ready  out  NUM_REQ  one-hot accept strobe; a byte transfers when valid&ready.
- uart_data  out  DATA_W  byte to uart_tx8; held stable from the start pulse until done.
- uart_start  out  1  single-cycle start pulse to uart_tx8.
- uart_busy  in  1  uart_tx8 busy.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last owner.
- frame_active  out  1  a frame lock is held.
- timeout_err  out  1  one-cycle pulse when busy never rose.

Behaviour:
- Reset values: req_ready=0, uart_data=0, uart_start=0, grant_id=0, frame_active=0, timeout_err=0; FSM=IDLE; rr_ptr=0.
- Reset mid-transfer aborts immediately. The byte in flight is abandoned, the lock is cleared, and nothing is replayed.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE, no lock:
  - winner = first i with req_valid, searching circularly from rr_ptr.
  - req_ready[winner]=1 combinationally, only when state==IDLE && uart_busy==0.
- IDLE, lock held: only grant_id is eligible. Other requesters wait regardless of their valid.
- An owner that drops valid mid-frame stalls the arbiter indefinitely. This is by design.
- On accept (edge where valid&ready):
  - uart_data <= req_data[winner]; grant_id <= winner; FSM -> START.
  - If req_last=0: frame_active <= 1.
  - If req_last=1: frame_active <= 0 and rr_ptr <= winner+1 (wrap to 0 at NUM_REQ).
  - A single-byte frame (last on the first byte) never asserts frame_active.
- START: uart_start=1 for exactly this cycle; FSM -> WAIT_BUSY; timeout counter cleared.
- WAIT_BUSY:
  - uart_busy=1 -> WAIT_DONE.
  - Otherwise the counter increments. At count==BUSY_TIMEOUT-1 with no busy: pulse timeout_err and go to IDLE.
  - On timeout the byte is dropped, lock state is unchanged and rr_ptr is unchanged.
- WAIT_DONE: uart_busy=0 -> IDLE.
- Latency: accept at cycle N, uart_start at N+1. Back-to-back accepts are separated by at least the UART frame time plus 3 cycles.
- req_ready never asserts outside IDLE. At most one bit of req_ready is set.
- Simultaneous valids with no lock: lowest index at or after rr_ptr wins.
- Busy already high in IDLE (external use): no accept until it is low.
- Counter width: $clog2(BUSY_TIMEOUT+1) bits; it saturates and never wraps.

Decomposition:
- Shared package uart_arb_pkg:
  - FSM state enum (2-bit).
  - Default DATA_W constant.
  - Function rr_pick(valid, ptr) returning the winner index plus a found flag.
- One natural sub-module: rr_priority_pick, the combinational circular priority encoder (NUM_REQ, valid, ptr -> idx, found).
- The FSM and the registers stay in uart_tx_arbiter.

Test Plan:
- Single requester:
  - Stimulus: req0 sends 0x41 with last=1; the busy model rises 2 cycles after start and falls 20 cycles later.
  - Required: ready0 pulses once, uart_start one cycle later, uart_data=0x41 held, rr_ptr=1.
- Frame lock:
  - Stimulus: req0 sends 3 bytes 0x10,0x11,0x12 (last on the third) while req1 holds valid with 0x99 throughout.
  - Required: 0x10,0x11,0x12 are sent before 0x99, frame_active stays high across the first two bytes, then 0x99 is sent.
- Round-robin:
  - Stimulus: req0 and req1 both present single-byte frames continuously, NUM_REQ=2.
  - Required: grant alternates 0,1,0,1 and no requester is granted twice in a row.
- Busy timeout:
  - Stimulus: busy model stuck low, BUSY_TIMEOUT=16.
  - Required: timeout_err pulses exactly 16 cycles after uart_start, FSM returns to IDLE, and the next byte is accepted.
- Reset mid-transfer:
  - Stimulus: assert reset during WAIT_DONE of a locked frame.
  - Required: all outputs 0 asynchronously, frame_active=0; after release, req1 can win immediately.
- External busy:
  - Stimulus: uart_busy=1 while in IDLE with req0 valid.
  - Required: req_ready stays 0 until busy falls, then accepts on the next edge.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding,
// default byte width and the circular round-robin pick function.
package uart_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int MAX_REQ    = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First asserted valid bit at or after ptr, wrapping at n (n <= MAX_REQ).
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0]         ptr,
                                    input int                 n);
    pick_t res;
    int    j;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (!res.found && valid[j[2:0]]) begin
          res.found = 1'b1;
          res.idx   = 3'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational circular priority encoder: lowest-index valid requester at or
// after ptr, wrapping at NUM_REQ.
module rr_priority_pick
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  pick_t res;

  // Widen to the package's fixed width, pick, then narrow back.
  always_comb begin
    res   = rr_pick(MAX_REQ'(valid), 3'(ptr), NUM_REQ);
    idx   = IDX_W'(res.idx);
    found = res.found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx8 between NUM_REQ byte-stream requesters. Round-robin at
// frame granularity with a frame lock, start/busy handshake sequencing and a
// watchdog for a busy that never rises.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 2,
  parameter  int DATA_W       = DATA_W_DEF,
  parameter  int BUSY_TIMEOUT = 16,
  localparam int IDX_W        = $clog2(NUM_REQ),
  localparam int CNT_W        = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         uart_data,
  output logic                      uart_start,
  input  logic                      uart_busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      frame_active,
  output logic                      timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUSY_TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  to_cnt;
  logic [IDX_W-1:0]  pick_idx, win_idx;
  logic              pick_found, win_found;
  logic              accept;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Winner selection: a held lock restricts eligibility to the current owner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the ifs leaves it unassigned and a latch is never inferred.
    win_idx   = pick_idx;
    win_found = pick_found;
    req_ready = '0;
    if (frame_active) begin
      win_idx   = grant_id;
      win_found = req_valid[grant_id];
    end
    accept = (state == ST_IDLE) && !uart_busy && win_found;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  // Next-state logic plus the start pulse and watchdog pulse.
  always_comb begin
    state_nxt   = state;
    uart_start  = 1'b0;
    timeout_err = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_START;
      end
      ST_START: begin
        uart_start = 1'b1;
        state_nxt  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (uart_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (to_cnt == CNT_LAST) begin
          timeout_err = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Datapath registers: latched byte, owner, lock, round-robin pointer and
  // the busy watchdog counter.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    // NOTE: the byte register is reset too, so uart_data reads 0 after reset
    // rather than a stale byte from an abandoned transfer.
    if (reset) begin
      uart_data    <= '0;
      grant_id     <= '0;
      frame_active <= 1'b0;
      rr_ptr       <= '0;
      to_cnt       <= '0;
    end else begin
      if (accept) begin
        uart_data    <= req_data[win_idx*DATA_W +: DATA_W];
        grant_id     <= win_idx;
        frame_active <= !req_last[win_idx];
        if (req_last[win_idx]) begin
          rr_ptr <= (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
        end
      end
      if (state == ST_START) begin
        to_cnt <= '0;
      end else if (state == ST_WAIT_BUSY && to_cnt != CNT_MAX) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: reset values, a table of IDLE arbitration
// vectors, frame-level reference-model runs (directed and random) and
// hand-written sequences for watchdog, mid-transfer reset and external busy.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DW      = 8;
  localparam int BT      = 16;

  logic                  CLOCK_50 = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;
  logic [DW-1:0]         uart_data;
  logic                  uart_start;
  logic                  uart_busy;
  logic [0:0]            grant_id;
  logic                  frame_active;
  logic                  timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DW), .BUSY_TIMEOUT(BT)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .uart_data    (uart_data),
    .uart_start   (uart_start),
    .uart_busy    (uart_busy),
    .grant_id     (grant_id),
    .frame_active (frame_active),
    .timeout_err  (timeout_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // uart_tx8 stand-in: mode 0 rises bm_dly cycles after start and stays high
  // bm_len cycles; mode 1 forces busy high; mode 2 holds it low.
  int bm_t    = -1;
  int bm_mode = 0;
  int bm_dly  = 2;
  int bm_len  = 20;

  initial begin
    uart_busy = 1'b0;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (reset)              bm_t = -1;
      else if (uart_start)    bm_t = 0;
      else if (bm_t >= 0)     bm_t++;
      if (bm_t >= bm_dly + bm_len) bm_t = -1;
      case (bm_mode)
        1:       uart_busy = 1'b1;
        2:       uart_busy = 1'b0;
        default: uart_busy = (bm_t >= bm_dly);
      endcase
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "bench time limit");
  end

  // Per-requester byte queues, expected and observed transmit sequences.
  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } rec_t;

  typedef struct {
    logic [DW-1:0] d;
    int            gid;
    logic          fa;
  } obs_t;

  rec_t q [NUM_REQ][$];
  obs_t exp_q[$];
  obs_t got_q[$];
  int   mptr = 0;

  // Frame-level round robin over requesters that present continuously.
  task automatic build_expected();
    rec_t m [NUM_REQ][$];
    rec_t r;
    int   left = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      m[i] = q[i];
      left += m[i].size();
    end
    exp_q.delete();
    while (left > 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int j = (mptr + k) % NUM_REQ;
        if (m[j].size() > 0) begin
          do begin
            r = m[j].pop_front();
            exp_q.push_back('{d: r.d, gid: j, fa: !r.last});
            left--;
          end while (!r.last && m[j].size() > 0);
          mptr = (j + 1) % NUM_REQ;
          break;
        end
      end
    end
  endtask

  task automatic add_frame(input int i, input int len, input logic [DW-1:0] base, input bit rnd);
    for (int b = 0; b < len; b++) begin
      q[i].push_back('{d: rnd ? DW'($urandom) : base + DW'(b), last: (b == len - 1)});
    end
  endtask

  // Drive queues as continuously-valid requesters and compare against model.
  task automatic run_engine(input string tag, input int bound);
    int acc_cyc[$];
    int st_cyc[$];
    int quiet = 0;
    int total = 0;
    logic [DW-1:0] held = '0;
    build_expected();
    for (int i = 0; i < NUM_REQ; i++) total += q[i].size();
    got_q.delete();
    for (int cyc = 0; cyc < bound && quiet < 3; cyc++) begin
      @(negedge CLOCK_50);
      for (int i = 0; i < NUM_REQ; i++) begin
        req_valid[i] = (q[i].size() > 0);
        req_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0].d : '0;
        req_last[i] = (q[i].size() > 0) ? q[i][0].last : 1'b0;
      end
      #1;
      check({tag, "_ready_onehot0"}, 32'($countones(req_ready) <= 1), 1);
      check({tag, "_no_timeout"}, timeout_err, 0);
      if (uart_busy) check({tag, "_ready_while_busy"}, req_ready, 0);
      if (uart_start) begin
        got_q.push_back('{d: uart_data, gid: int'(grant_id), fa: frame_active});
        st_cyc.push_back(cyc);
        held = uart_data;
      end else if (uart_busy && got_q.size() > 0) begin
        check({tag, "_data_held"}, uart_data, held);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) begin
          check({tag, "_ready_has_valid"}, req_valid[i], 1);
          void'(q[i].pop_front());
          acc_cyc.push_back(cyc);
        end
      end
      if (q[0].size() == 0 && q[1].size() == 0 && !uart_busy && !uart_start && bm_t < 0)
        quiet++;
      else
        quiet = 0;
    end
    req_valid = '0;
    check({tag, "_finished"}, 32'(quiet >= 3), 1);
    check({tag, "_accepts"}, acc_cyc.size(), total);
    check({tag, "_starts"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      check({tag, "_data"}, got_q[k].d, exp_q[k].d);
      check({tag, "_grant"}, got_q[k].gid, exp_q[k].gid);
      check({tag, "_frame_active"}, got_q[k].fa, exp_q[k].fa);
      if (k < acc_cyc.size()) check({tag, "_start_latency"}, st_cyc[k] - acc_cyc[k], 1);
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    bm_mode   = 0;
    bm_dly    = 2;
    bm_len    = 20;
    mptr      = 0;
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int qc = 0;
    for (int c = 0; c < 300 && qc < 3; c++) begin
      @(negedge CLOCK_50);
      #1;
      if (!uart_busy && !uart_start && bm_t < 0) qc++;
      else qc = 0;
    end
    check(name, 32'(qc >= 3), 1);
  endtask

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    logic               busy_hi;
    logic [NUM_REQ-1:0] exp_ready;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // IDLE arbitration vectors applied from reset (rr_ptr=0, no lock).
    vecs.push_back('{valid: 2'b00, busy_hi: 1'b0, exp_ready: 2'b00});
    vecs.push_back('{valid: 2'b01, busy_hi: 1'b0, exp_ready: 2'b01});
    vecs.push_back('{valid: 2'b10, busy_hi: 1'b0, exp_ready: 2'b10});
    vecs.push_back('{valid: 2'b11, busy_hi: 1'b0, exp_ready: 2'b01});
    vecs.push_back('{valid: 2'b11, busy_hi: 1'b1, exp_ready: 2'b00});
    vecs.push_back('{valid: 2'b10, busy_hi: 1'b1, exp_ready: 2'b00});
    vecs.push_back('{valid: 2'b01, busy_hi: 1'b1, exp_ready: 2'b00});

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    #35;
    check("rst_ready", req_ready, 0);
    check("rst_data", uart_data, 0);
    check("rst_start", uart_start, 0);
    check("rst_grant", grant_id, 0);
    check("rst_frame_active", frame_active, 0);
    check("rst_timeout", timeout_err, 0);
    apply_reset();

    foreach (vecs[v]) begin
      @(negedge CLOCK_50);
      bm_mode   = vecs[v].busy_hi ? 1 : 0;
      req_valid = '0;
      @(negedge CLOCK_50);
      req_valid = vecs[v].valid;
      req_last  = '1;
      #1;
      check($sformatf("vec%0d_ready", v), req_ready, vecs[v].exp_ready);
      check($sformatf("vec%0d_start", v), uart_start, 0);
      #1;
      req_valid = '0;
    end
    bm_mode = 0;
    repeat (2) @(negedge CLOCK_50);

    // Single requester: one byte, then rr_ptr must favour requester 1.
    add_frame(0, 1, 8'h41, 1'b0);
    run_engine("single", 400);
    add_frame(0, 1, 8'h42, 1'b0);
    add_frame(1, 1, 8'h43, 1'b0);
    run_engine("rr_ptr", 400);

    // Frame lock: three-byte frame from req0 while req1 waits with 0x99.
    apply_reset();
    add_frame(0, 3, 8'h10, 1'b0);
    add_frame(1, 1, 8'h99, 1'b0);
    run_engine("lock", 600);

    // Round robin with both requesters presenting single-byte frames.
    for (int f = 0; f < 4; f++) begin
      add_frame(0, 1, 8'hA0 + DW'(f), 1'b0);
      add_frame(1, 1, 8'hB0 + DW'(f), 1'b0);
    end
    run_engine("rr", 1200);
    for (int k = 1; k < got_q.size(); k++) begin
      check("rr_alternate", 32'(got_q[k].gid != got_q[k-1].gid), 1);
    end

    // Random frames and busy timing against the frame-level model.
    for (int it = 0; it < 3; it++) begin
      bm_dly = $urandom_range(1, 4);
      bm_len = $urandom_range(3, 25);
      for (int i = 0; i < NUM_REQ; i++) begin
        int nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) add_frame(i, $urandom_range(1, 3), '0, 1'b1);
      end
      run_engine($sformatf("rand%0d", it), 3000);
    end

    // Busy timeout: busy stuck low.
    begin
      int first  = -1;
      int pulses = 0;
      int n      = 0;
      apply_reset();
      bm_mode = 2;
      @(negedge CLOCK_50);
      req_valid = 2'b01;
      req_data  = {8'h00, 8'h5A};
      req_last  = 2'b01;
      #1;
      check("to_ready", req_ready, 2'b01);
      @(negedge CLOCK_50);
      req_valid = '0;
      #1;
      check("to_start", uart_start, 1);
      for (int k = 1; k <= 20; k++) begin
        @(negedge CLOCK_50);
        #1;
        if (timeout_err) begin
          pulses++;
          if (first < 0) first = k;
        end
        if (k <= 17) check("to_no_restart", uart_start, 0);
        if (k == 17) begin
          req_valid = 2'b01;
          req_data  = {8'h00, 8'h5B};
          #1;
          check("to_reaccept_ready", req_ready, 2'b01);
        end
        if (k == 18) begin
          check("to_reaccept_start", uart_start, 1);
          check("to_reaccept_data", uart_data, 8'h5B);
          req_valid = '0;
        end
      end
      check("to_pulse_cycle", first, BT);
      check("to_pulse_count", pulses, 1);
      while (!timeout_err && n < 40) begin
        @(negedge CLOCK_50);
        #1;
        n++;
      end
      check("to_second_timeout", timeout_err, 1);
      bm_mode = 0;
    end

    // Reset during WAIT_DONE of a locked frame.
    begin
      int n = 0;
      apply_reset();
      @(negedge CLOCK_50);
      req_valid = 2'b11;
      req_data  = {8'h77, 8'h20};
      req_last  = 2'b10;
      #1;
      check("mr_ready", req_ready, 2'b01);
      @(negedge CLOCK_50);
      #1;
      check("mr_start", uart_start, 1);
      while (!uart_busy && n < 10) begin
        @(negedge CLOCK_50);
        #1;
        n++;
      end
      check("mr_busy_seen", uart_busy, 1);
      @(negedge CLOCK_50);
      #1;
      check("mr_locked", frame_active, 1);
      reset = 1'b1;
      #1;
      check("mr_rst_ready", req_ready, 0);
      check("mr_rst_data", uart_data, 0);
      check("mr_rst_start", uart_start, 0);
      check("mr_rst_grant", grant_id, 0);
      check("mr_rst_frame_active", frame_active, 0);
      check("mr_rst_timeout", timeout_err, 0);
      repeat (2) @(negedge CLOCK_50);
      reset     = 1'b0;
      req_valid = 2'b10;
      #1;
      check("mr_req1_wins", req_ready, 2'b10);
      @(negedge CLOCK_50);
      req_valid = '0;
      #1;
      check("mr_req1_start", uart_start, 1);
      check("mr_req1_data", uart_data, 8'h77);
      check("mr_req1_grant", grant_id, 1);
      wait_quiet("mr_quiet");
    end

    // External busy high while idle with req0 valid.
    bm_mode = 1;
    repeat (2) @(negedge CLOCK_50);
    req_valid = 2'b01;
    req_data  = {8'h00, 8'h3C};
    req_last  = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("xb_ready_held", req_ready, 0);
      check("xb_no_start", uart_start, 0);
      @(negedge CLOCK_50);
    end
    bm_mode = 0;
    @(negedge CLOCK_50);
    #1;
    check("xb_ready_after", req_ready, 2'b01);
    @(negedge CLOCK_50);
    req_valid = '0;
    #1;
    check("xb_start", uart_start, 1);
    check("xb_data", uart_data, 8'h3C);
    wait_quiet("xb_quiet");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
